// File: rtl/oled_spi_pkg.sv
// ---------------------------------------------------------------------------
// oled_spi_pkg
// Shared definitions for the OLED SPI packet arbiter: arbiter state
// encodings, the byte-count field width, the default packet geometry of the
// Nbit_MOSI_SPI_Buffer, and a packet-count validity helper.
// ---------------------------------------------------------------------------
package oled_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_REJECT = 3'd2,
    ST_LOAD   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  localparam int COUNT_W   = 5;
  localparam int BUF_WIDTH = 8;
  localparam int BUF_N     = 8;

  // A packet is sendable only if it carries 1..n bytes.
  function automatic logic count_valid(input logic [COUNT_W-1:0] count,
                                       input int n);
    return (count != '0) && (int'(count) <= n);
  endfunction

endpackage

// File: rtl/oled_spi_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker. The search starts one past ptr_i and
// wraps modulo NREQ; the first asserted request wins.
//   req_i   : request vector
//   ptr_i   : index of the previous winner
//   grant_o : one-hot winner (all zero when no request)
//   idx_o   : binary index of the winner
//   any_o   : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_select #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise unassigned paths infer latches.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + 1 + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/oled_spi_arbiter.sv
// ---------------------------------------------------------------------------
// oled_spi_arbiter
// Shares one Nbit_MOSI_SPI_Buffer between NREQ packet requesters. Grants one
// requester, latches its packet into the buffer load port, pulses the buffer
// start, waits for the final-byte flag, frames the transfer with chip select
// and enforces a GAP-cycle inter-packet gap with CS high.
//
// Build option: OLED_ARB_FIXED_PRIORITY_EN -- when defined, the lowest-index
// request always wins; otherwise round-robin (default).
//
// Ports:
//   i_SCK, i_RST          clock, synchronous active-high reset
//   i_REQ                 per-requester level request
//   i_REQ_DATA/DC/COUNT   per-requester packet slices (slice k = requester k)
//   o_GRANT               one-hot grant held for the packet
//   o_DONE, o_ERR         completion pulse; o_ERR marks a rejected packet
//   o_BUF_DATA/DC/N_TRANSMIT, o_BUF_START   buffer load port
//   i_BUF_FINAL_BYTE      buffer final-byte flag
//   o_CS                  OLED chip select, active-low
//   o_BUSY                high whenever not IDLE
// ---------------------------------------------------------------------------
module oled_spi_arbiter
  import oled_spi_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = BUF_WIDTH,
  parameter int N     = BUF_N,
  parameter int GAP   = 2
) (
  input  logic                      i_SCK,
  input  logic                      i_RST,
  input  logic [NREQ-1:0]           i_REQ,
  input  logic [NREQ*WIDTH*N-1:0]   i_REQ_DATA,
  input  logic [NREQ*N-1:0]         i_REQ_DC,
  input  logic [NREQ*COUNT_W-1:0]   i_REQ_COUNT,
  output logic [NREQ-1:0]           o_GRANT,
  output logic [NREQ-1:0]           o_DONE,
  output logic                      o_ERR,
  output logic [WIDTH*N-1:0]        o_BUF_DATA,
  output logic [N-1:0]              o_BUF_DC,
  output logic [COUNT_W-1:0]        o_BUF_N_TRANSMIT,
  output logic                      o_BUF_START,
  input  logic                      i_BUF_FINAL_BYTE,
  output logic                      o_CS,
  output logic                      o_BUSY
);

  localparam int IDX_W            = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PKT_W            = WIDTH * N;
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  state_e state_q, state_d;

  logic [NREQ-1:0]    grant_q, done_q;
  logic               err_q;
  logic [PKT_W-1:0]   buf_data_q;
  logic [N-1:0]       buf_dc_q;
  logic [COUNT_W-1:0] buf_cnt_q;
  logic [3:0]         gap_q;

  // Arbitration result, valid while in ARB.
  logic [NREQ-1:0]    win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [PKT_W-1:0]   win_data;
  logic [N-1:0]       win_dc;
  logic [COUNT_W-1:0] win_count;
  logic               win_valid;

`ifdef OLED_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_any && i_REQ[i]) begin
        win_any       = 1'b1;
        win_onehot[i] = 1'b1;
        win_idx       = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q;

  rr_select #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_select (
    .req_i   (i_REQ),
    .ptr_i   (ptr_q),
    .grant_o (win_onehot),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      ptr_q <= IDX_W'(NREQ - 1);
    end else if (state_q == ST_ARB && win_any) begin
      ptr_q <= win_idx;
    end
  end
`endif

  assign win_data  = i_REQ_DATA[int'(win_idx)*PKT_W +: PKT_W];
  assign win_dc    = i_REQ_DC[int'(win_idx)*N +: N];
  assign win_count = i_REQ_COUNT[int'(win_idx)*COUNT_W +: COUNT_W];
  assign win_valid = count_valid(win_count, N);

  always_ff @(posedge i_SCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|i_REQ) state_d = ST_ARB;
      // Requests withdrawn between IDLE and ARB leave nothing to grant.
      ST_ARB:    if (!win_any)       state_d = ST_IDLE;
                 else if (win_valid) state_d = ST_LOAD;
                 else                state_d = ST_REJECT;
      ST_REJECT: state_d = ST_GAP;
      ST_LOAD:   state_d = ST_WAIT;
      ST_WAIT:   if (i_BUF_FINAL_BYTE) state_d = ST_GAP;
      ST_GAP:    if (gap_q == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_SCK) begin
    // NOTE: the latched packet registers are reset along with control state
    // so the buffer port reads zero after reset; they are plain registers,
    // not a memory array, so resetting them is cheap.
    if (i_RST) begin
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      buf_data_q <= '0;
      buf_dc_q   <= '0;
      buf_cnt_q  <= '0;
      gap_q      <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_ARB: begin
          if (win_any) begin
            grant_q    <= win_onehot;
            buf_data_q <= win_data;
            buf_dc_q   <= win_dc;
            buf_cnt_q  <= win_count;
            // A rejected packet completes in REJECT with done and err.
            if (!win_valid) begin
              done_q <= win_onehot;
              err_q  <= 1'b1;
            end
          end
        end
        ST_REJECT: begin
          grant_q <= '0;
          gap_q   <= GAP_LOAD;
        end
        ST_WAIT: begin
          if (i_BUF_FINAL_BYTE) begin
            done_q  <= grant_q;
            grant_q <= '0;
            gap_q   <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_q != '0) gap_q <= gap_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_GRANT          = grant_q;
  assign o_DONE           = done_q;
  assign o_ERR            = err_q;
  assign o_BUF_DATA       = buf_data_q;
  assign o_BUF_DC         = buf_dc_q;
  assign o_BUF_N_TRANSMIT = buf_cnt_q;
  // Start is high only in LOAD: a high start at the final byte would make
  // the buffer relaunch.
  assign o_BUF_START      = (state_q == ST_LOAD);
  assign o_CS             = !((state_q == ST_LOAD) || (state_q == ST_WAIT));
  assign o_BUSY           = (state_q != ST_IDLE);

endmodule

// File: doc/oled_spi_arbiter.md
# oled_spi_arbiter

Shares one `Nbit_MOSI_SPI_Buffer` instance between `NREQ` packet requesters, such as the SSD1331 init sequencer and the pixel/draw engines. The block grants one requester at a time and latches that requester's packet into the buffer's load port. It pulses the buffer start for one cycle, waits for the buffer's final-byte flag, then frames the transfer with chip-select and enforces an inter-packet gap. It sits between the requesters and the buffer, on the same `i_SCK` domain.

## Interface
- `NREQ`, 2, number of requesters (2..8)
- `WIDTH`, 8, bits per byte; must match the buffer
- `N`, 8, maximum bytes per packet; must match the buffer
- `GAP`, 2, cycles CS is held high between packets (1..15)

Ports:
- `i_SCK`  in  1  clock. Single clock domain.
- `i_RST`  in  1  reset. Synchronous, active-high.
- `i_REQ`  in  NREQ  per-requester packet request, level
- `i_REQ_DATA`  in  NREQ*WIDTH*N  packet bytes; requester k occupies slice k; byte 0 is in the LSBs
- `i_REQ_DC`  in  NREQ*N  D/C bit per byte, slice k
- `i_REQ_COUNT`  in  NREQ*5  byte count, slice k
- `o_GRANT`  out  NREQ  one-hot grant, held for the whole packet
- `o_DONE`  out  NREQ  one-cycle completion pulse to the granted requester
- `o_ERR`  out  1  one-cycle pulse coincident with `o_DONE` when the packet was rejected
- `o_BUF_DATA`  out  WIDTH*N  to buffer `i_DATA`
- `o_BUF_DC`  out  N  to buffer `i_DC`
- `o_BUF_N_TRANSMIT`  out  5  to buffer `i_N_transmit`
- `o_BUF_START`  out  1  to buffer `i_START`
- `i_BUF_FINAL_BYTE`  in  1  from buffer `o_MOSI_FINAL_BYTE`
- `o_CS`  out  1  OLED chip select, active-low
- `o_BUSY`  out  1  high in every state except IDLE

## Operation
- Reset values: state IDLE; `o_GRANT`, `o_DONE`, `o_ERR`, `o_BUF_START` = 0; `o_BUF_*` data = 0; `o_CS` = 1; `o_BUSY` = 0; round-robin pointer = NREQ-1; gap counter = 0.
- States:
  - **IDLE → ARB**: taken when any `i_REQ` bit is high.
  - **ARB**: select a winner.
    - Search starts at pointer+1 and wraps modulo NREQ.
    - Register the one-hot `o_GRANT` and latch the winner's data, DC and count into `o_BUF_*`.
    - Update the pointer to the winner.
    - Validity: if count is 0 or count > N, go to REJECT. Otherwise go to LOAD.
  - **REJECT**: pulse `o_DONE[k]` and `o_ERR` for one cycle. No buffer activity; CS stays high. Go to GAP.
  - **LOAD**: `o_BUF_START`=1 for exactly this cycle; `o_CS`=0. Go to WAIT.
  - **WAIT**:
    - `o_BUF_START`=0. It must stay low: the buffer re-launches if start is high at its final byte.
    - `o_CS`=0.
    - When `i_BUF_FINAL_BYTE`=1, pulse `o_DONE[k]` and go to GAP.
  - **GAP**:
    - `o_CS`=1; `o_GRANT` cleared.
    - Count GAP cycles, then go to IDLE. The counter loads GAP-1 on entry and exits when it reaches 0.
- Requester rules:
  - Hold `i_REQ` and the packet slice stable until `o_DONE`.
  - Dropping `i_REQ` before a grant withdraws the request. Dropping it after the grant has no effect; the packet completes.
- `o_BUF_*` data holds its last value outside a packet. The buffer ignores it while start is low.
- Reset mid-packet: all state returns to reset values in one cycle and no `o_DONE` is issued. The buffer shares `i_RST`, so it aborts in the same cycle.

## Timing
- Latency from `i_REQ` rising in IDLE: grant visible after 2 edges (IDLE→ARB→LOAD); `o_BUF_START` high on the 2nd cycle after the request.
- `o_DONE` rises the cycle after `i_BUF_FINAL_BYTE` is sampled high.
- Minimum gap between `o_DONE` and the next `o_BUF_START`: GAP+2 cycles.
- A `i_BUF_FINAL_BYTE` pulse outside WAIT is ignored.

## Configuration
- `OLED_ARB_FIXED_PRIORITY_EN`:
  - Defined: ARB always picks the lowest-index asserted request; the pointer is unused and may be optimized away.
  - Undefined (default): round-robin as described under Operation.

## Structure
- Shared package `oled_spi_pkg` holds:
  - state encodings `ST_IDLE`, `ST_ARB`, `ST_REJECT`, `ST_LOAD`, `ST_WAIT`, `ST_GAP`
  - constant `COUNT_W = 5`
  - the buffer's default WIDTH and N
- One sub-module: `rr_select`, a combinational one-hot round-robin picker taking requests and pointer and returning the one-hot winner and its index. The fixed-priority path bypasses it.

## Test plan
- Single request, requester 0, count 3, data 0xA0/0xA1/0xA2, DC 3'b001 → `o_BUF_START` one cycle with `o_BUF_N_TRANSMIT`=3; CS low until final byte; one `o_DONE[0]`; CS high for 2 cycles.
- `i_REQ`=2'b11 held continuously, round-robin build → grants alternate 0,1,0,1; each `o_DONE` matches its grant.
- Same stimulus with `OLED_ARB_FIXED_PRIORITY_EN` → requester 0 granted every packet.
- Count 0, then count 9 with N=8 → `o_DONE` and `o_ERR` pulse; `o_BUF_START` and `o_CS` never asserted.
- `i_RST` asserted in WAIT after the 2nd of 4 bytes → next cycle all outputs at reset values; no `o_DONE`; a new request afterwards completes normally.
- `i_BUF_FINAL_BYTE` forced high during IDLE and GAP → no state change and no `o_DONE`.
